// File: rtl/step_sequencer.sv
// Step sequencer: walks step codes 0..LAST_STEP through ISSUE/EXEC/WRITE phases
// and raises done at the end of a run. Outputs decode from registered state only.
module step_sequencer #(
  parameter int STEP_W      = 3,
  parameter int LAST_STEP   = 7,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic [STEP_W-1:0] step,
  output logic              rf_rd_en,
  output logic              rf_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [STEP_W-1:0] LAST     = STEP_W'(LAST_STEP);
  localparam logic [3:0]        CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [STEP_W-1:0] step_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        step_n = '0;
        if (start) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_n   = CNT_INIT;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          if (cnt == '0) state_n = S_WRITE;
          else           cnt_n   = cnt - 4'd1;
        end
      end
      // stall is deliberately ignored here so a started commit always lands
      S_WRITE: begin
        if (step == LAST) begin
          state_n = S_DONE;
        end else begin
          step_n  = step + 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_DONE: begin
        if (start) begin
          step_n  = '0;
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      step_n  = '0;
      cnt_n   = '0;
    end
  end

  assign rf_rd_en = (state == S_ISSUE);
  assign rf_we    = (state == S_WRITE);
  assign busy     = (state == S_ISSUE) || (state == S_EXEC) || (state == S_WRITE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with default parameters (8 steps, 2 EXEC cycles).
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, stall;
  logic [2:0] step;
  logic       rf_rd_en, rf_we, busy, done;

  int errors = 0;
  int checks = 0;

  step_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .step(step), .rf_rd_en(rf_rd_en), .rf_we(rf_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic rd,
                         input logic we, input logic b, input logic d);
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".rd"},   32'(rf_rd_en), 32'(rd));
    chk({tag, ".we"},   32'(rf_we), 32'(we));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Full run from IDLE/DONE. Reference timeline: 4 cycles per step, ISSUE at
  // e%4==0, WRITE at e%4==3; an optional 5-cycle stall freezes step 2's EXEC.
  task automatic run(input string tag, input bit do_stall, input bit do_pulse);
    int total, e, we_cnt;
    total  = do_stall ? 37 : 32;
    we_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out({tag, ".issue0"}, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= total; n++) begin
      tick();
      if (do_stall && n >= 10 && n <= 14) begin
        chk_out({tag, ".stalled"}, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        e = (do_stall && n > 14) ? n - 5 : n;
        if (e < 32) begin
          chk({tag, ".step"}, 32'(step), 32'(e / 4));
          chk({tag, ".rd"},   32'(rf_rd_en), 32'(e % 4 == 0));
          chk({tag, ".we"},   32'(rf_we), 32'(e % 4 == 3));
        end else begin
          chk_out({tag, ".done"}, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end
      if (rf_we) we_cnt++;
      if (do_stall && n == 9)  stall = 1'b1;
      if (do_stall && n == 14) stall = 1'b0;
      if (do_pulse) start = (n == 10);
    end
    chk({tag, ".we_pulses"}, 32'(we_cnt), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    chk_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // full run, then DONE holds with start low
    run("run1", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_out("done_hold", 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);

    // restart from DONE with a start pulse mid-run
    run("restart", 1'b0, 1'b1);

    // 5-cycle stall in step 2 EXEC
    run("stall", 1'b1, 1'b0);

    // abort during step 4 EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) tick();
    chk_out("pre_abort", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    stall = 1'b1;
    tick();
    chk_out("abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    chk_out("abort_over_start", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0; stall = 1'b0; start = 1'b0;
    tick();
    chk_out("abort_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("post_abort", 1'b0, 1'b0);

    // asynchronous reset in step 6 WRITE
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 27; n++) tick();
    chk_out("pre_reset", 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("post_reset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
